if2_predecode_ras: RTL and testbench

IF2_PREDECODE_RAS -- requirements
Module: if2_predecode_ras

---
 rtl/if2_predecode_ras_if.sv | 31 +++
 rtl/if2_predecode_ras.sv | 171 +++++++++++++++++
 tb/tb_if2_predecode_ras.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/if2_predecode_ras_if.sv
// Fetch-packet bus into and out of the IF2 predecoder; master is the fetch/backend side.
interface if2_predecode_ras_if #(
  parameter int FETCH_W = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_pc;
  logic [32*FETCH_W-1:0] in_ir;
  logic [FETCH_W-1:0]    in_slot_valid;
  logic [34*FETCH_W-1:0] in_brtype_pcpre;
  logic [31:0]           in_pred_npc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_pc;
  logic [32*FETCH_W-1:0] out_ir;
  logic [FETCH_W-1:0]    out_slot_valid;
  logic [34*FETCH_W-1:0] out_type_pcpre;
  logic                  out_redirect;
  logic [31:0]           out_npc;

  modport master (
    output in_valid, in_pc, in_ir, in_slot_valid, in_brtype_pcpre, in_pred_npc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_ir, out_slot_valid, out_type_pcpre, out_redirect, out_npc
  );

  modport slave (
    input  in_valid, in_pc, in_ir, in_slot_valid, in_brtype_pcpre, in_pred_npc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_ir, out_slot_valid, out_type_pcpre, out_redirect, out_npc
  );
endinterface

// File: rtl/if2_predecode_ras.sv
// IF2 predecode: resolves branch targets per slot, truncates after the first taken slot, keeps a RAS.
// One register stage; in_ready = !out_valid || out_ready, outputs hold while stalled, flush kills the stage.
module if2_predecode_ras #(
  parameter int FETCH_W   = 2,
  parameter int RAS_DEPTH = 8
) (
  input logic              clk,
  input logic              rstn,
  if2_predecode_ras_if.slave io_bus
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [31:0]           r_ras [RAS_DEPTH];
  logic [PW-1:0]         r_ptr;
  logic [PW:0]           r_cnt;
  logic                  r_out_valid;
  logic [31:0]           r_out_pc;
  logic [32*FETCH_W-1:0] r_out_ir;
  logic [FETCH_W-1:0]    r_out_sv;
  logic [34*FETCH_W-1:0] r_out_tp;
  logic                  r_out_redirect;
  logic [31:0]           r_out_npc;

  logic [31:0]           w_ras_top;
  logic [32*FETCH_W-1:0] w_tgt_all;
  logic [32*FETCH_W-1:0] w_pc4_all;
  logic [34*FETCH_W-1:0] w_type_pcpre;
  logic [FETCH_W-1:0]    w_taken;
  logic [FETCH_W-1:0]    w_bl;
  logic [FETCH_W-1:0]    w_ret;
  logic [FETCH_W-1:0]    w_sv;
  logic [31:0]           w_npc;
  logic [31:0]           w_push_val;
  logic                  w_found;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_redirect;
  logic                  w_in_ready;
  logic                  w_accept;

  // r_ptr is the next write slot, so the top sits one below it.
  assign w_ras_top = r_ras[r_ptr - PW'(1)];

  for (genvar g = 0; g < FETCH_W; g++) begin : g_slot
    logic [31:0] w_ir, w_pc, w_pc4, w_off16, w_off26, w_br16, w_br26, w_btb_tgt, w_tgt;
    logic [5:0]  w_op;
    logic [1:0]  w_btb_type, w_type;
    logic        w_is_cond, w_is_b, w_is_bl, w_is_jirl, w_is_ret;

    assign w_ir       = io_bus.in_ir[32*g +: 32];
    assign w_btb_tgt  = io_bus.in_brtype_pcpre[34*g +: 32];
    assign w_btb_type = io_bus.in_brtype_pcpre[34*g+32 +: 2];
    assign w_pc       = io_bus.in_pc + 32'(4*g);
    assign w_pc4      = w_pc + 32'd4;
    assign w_op       = w_ir[31:26];
    assign w_off16    = {{14{w_ir[25]}}, w_ir[25:10], 2'b00};
    assign w_off26    = {{4{w_ir[9]}}, w_ir[9:0], w_ir[25:10], 2'b00};
    assign w_br16     = w_pc + w_off16;
    assign w_br26     = w_pc + w_off26;
    assign w_is_cond  = (w_op >= 6'h16) && (w_op <= 6'h1B);
    assign w_is_b     = (w_op == 6'h14);
    assign w_is_bl    = (w_op == 6'h15);
    assign w_is_jirl  = (w_op == 6'h13);
    assign w_is_ret   = w_is_jirl && (w_ir[4:0] == 5'd0) && (w_ir[9:5] == 5'd1) && (w_ir[25:10] == 16'd0);

    always_comb begin
      w_tgt  = w_pc4;
      w_type = 2'b00;
      if (w_is_b || w_is_bl) begin
        w_type = w_is_bl ? 2'b10 : 2'b01;
        w_tgt  = w_br26;
      end else if (w_is_jirl) begin
        w_type = 2'b11;
        w_tgt  = (w_is_ret && (r_cnt != '0)) ? w_ras_top : w_btb_tgt;
      end else if (w_is_cond) begin
        w_type = 2'b01;
        // Trust the BTB only if it agrees with one of the two legal outcomes; else backward-taken.
        if ((w_btb_type == 2'b01) && ((w_btb_tgt == w_br16) || (w_btb_tgt == w_pc4)))
          w_tgt = w_btb_tgt;
        else if (w_off16[31])
          w_tgt = w_br16;
      end
    end

    assign w_tgt_all[32*g +: 32]    = w_tgt;
    assign w_pc4_all[32*g +: 32]    = w_pc4;
    assign w_type_pcpre[34*g +: 34] = {w_type, w_tgt};
    assign w_taken[g]               = io_bus.in_slot_valid[g] && (w_tgt != w_pc4);
    assign w_bl[g]                  = w_is_bl;
    assign w_ret[g]                 = w_is_ret;
  end

  always_comb begin
    w_found    = 1'b0;
    w_npc      = io_bus.in_pred_npc;
    w_sv       = '0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_push_val = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (!w_found) begin
        w_sv[i] = io_bus.in_slot_valid[i];
        if (io_bus.in_slot_valid[i]) w_npc = w_pc4_all[32*i +: 32];
        if (w_taken[i]) begin
          w_found    = 1'b1;
          w_npc      = w_tgt_all[32*i +: 32];
          w_push     = w_bl[i];
          w_pop      = w_ret[i];
          w_push_val = w_pc4_all[32*i +: 32];
        end
      end
    end
  end

  assign w_redirect = (|io_bus.in_slot_valid) && (w_npc != io_bus.in_pred_npc);
  assign w_in_ready = !r_out_valid || io_bus.out_ready;
  assign w_accept   = io_bus.in_valid && w_in_ready && !io_bus.flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_ir       <= '0;
      r_out_sv       <= '0;
      r_out_tp       <= '0;
      r_out_redirect <= 1'b0;
      r_out_npc      <= '0;
    end else if (io_bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_out_valid <= io_bus.in_valid;
      if (io_bus.in_valid) begin
        r_out_pc       <= io_bus.in_pc;
        r_out_ir       <= io_bus.in_ir;
        r_out_sv       <= w_sv;
        r_out_tp       <= w_type_pcpre;
        r_out_redirect <= w_redirect;
        r_out_npc      <= w_npc;
      end
    end
  end

  // Push on full overwrites the oldest entry: the pointer simply wraps.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_push) begin
        r_ptr <= r_ptr + PW'(1);
        if (r_cnt != (PW+1)'(RAS_DEPTH)) r_cnt <= r_cnt + (PW+1)'(1);
      end else if (w_pop && (r_cnt != '0)) begin
        r_ptr <= r_ptr - PW'(1);
        r_cnt <= r_cnt - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w_accept && w_push) r_ras[r_ptr] <= w_push_val;
  end

  assign io_bus.in_ready       = w_in_ready;
  assign io_bus.out_valid      = r_out_valid;
  assign io_bus.out_pc         = r_out_pc;
  assign io_bus.out_ir         = r_out_ir;
  assign io_bus.out_slot_valid = r_out_sv;
  assign io_bus.out_type_pcpre = r_out_tp;
  assign io_bus.out_redirect   = r_out_redirect;
  assign io_bus.out_npc        = r_out_npc;
endmodule

// File: tb/tb_if2_predecode_ras.sv
// Directed bench for if2_predecode_ras (FETCH_W=2, RAS_DEPTH=8) with hand-computed expectations.
module tb_if2_predecode_ras;
  localparam int FW = 2;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] B40    = 32'h5000_4000;  // b +0x40
  localparam logic [31:0] BL100  = 32'h5401_0000;  // bl +0x100
  localparam logic [31:0] RET    = 32'h4C00_0020;  // jirl r0, r1, 0
  localparam logic [31:0] BEQM8  = 32'h5BFF_F843;  // beq -8
  localparam logic [31:0] BEQP16 = 32'h5800_1000;  // beq +16

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  if2_predecode_ras_if #(.FETCH_W(FW)) bus ();

  if2_predecode_ras #(.FETCH_W(FW), .RAS_DEPTH(8)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .io_bus(bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ir0, input logic [31:0] ir1,
                       input logic [1:0] sv, input logic [33:0] bt0, input logic [33:0] bt1,
                       input logic [31:0] pred);
    bus.in_valid        = 1'b1;
    bus.in_pc           = pc;
    bus.in_ir           = {ir1, ir0};
    bus.in_slot_valid   = sv;
    bus.in_brtype_pcpre = {bt1, bt0};
    bus.in_pred_npc     = pred;
  endtask

  // Present one packet at a negedge with out_ready high, let it be accepted, sample #1 after the edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] ir0, input logic [31:0] ir1,
                      input logic [1:0] sv, input logic [33:0] bt0, input logic [33:0] bt1,
                      input logic [31:0] pred);
    @(negedge clk);
    drive(pc, ir0, ir1, sv, bt0, bt1, pred);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_ir = '0;
    bus.in_slot_valid = '0;
    bus.in_brtype_pcpre = '0;
    bus.in_pred_npc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with a bl in flight: it must be lost and must not reach the RAS.
    drive(32'h0000_2000, BL100, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_2100);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_redirect", bus.out_redirect, 0);
    chk("rst_out_npc", bus.out_npc, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_ir", bus.out_ir, 0);
    chk("rst_out_sv", bus.out_slot_valid, 0);
    chk("rst_out_tp", bus.out_type_pcpre, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", bus.out_valid, 0);

    // Return with an empty RAS falls back to the BTB target.
    send(32'h0000_0500, RET, NOP, 2'b11, {2'b11, 32'h0077_7700}, 34'd0, 32'h0000_0508);
    chk("ret_empty_npc", bus.out_npc, 32'h0077_7700);
    chk("ret_empty_redir", bus.out_redirect, 1);

    // Slot0 b +0x40 at 0x1000.
    send(32'h0000_1000, B40, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_1008);
    chk("b_valid", bus.out_valid, 1);
    chk("b_redirect", bus.out_redirect, 1);
    chk("b_npc", bus.out_npc, 32'h0000_1040);
    chk("b_sv", bus.out_slot_valid, 2'b01);
    chk("b_pc", bus.out_pc, 32'h0000_1000);
    chk("b_tp", bus.out_type_pcpre, {2'b00, 32'h0000_1008, 2'b01, 32'h0000_1040});

    // bl at 0x2000 then a return: the return pops 0x2004.
    @(negedge clk);
    chk("in_ready_full_rate", bus.in_ready, 1);
    send(32'h0000_2000, BL100, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_2100);
    chk("bl_npc", bus.out_npc, 32'h0000_2100);
    chk("bl_redirect", bus.out_redirect, 0);
    chk("bl_tp", bus.out_type_pcpre[33:0], {2'b10, 32'h0000_2100});
    send(32'h0000_2100, RET, NOP, 2'b11, {2'b11, 32'hDEAD_0000}, 34'd0, 32'h0000_2108);
    chk("ret_pop_npc", bus.out_npc, 32'h0000_2004);
    chk("ret_pop_redir", bus.out_redirect, 1);
    chk("ret_pop_sv", bus.out_slot_valid, 2'b01);
    chk("ret_pop_tp", bus.out_type_pcpre[33:0], {2'b11, 32'h0000_2004});
    send(32'h0000_3000, RET, NOP, 2'b11, {2'b11, 32'h0000_5550}, 34'd0, 32'h0000_5550);
    chk("ret_after_pop_npc", bus.out_npc, 32'h0000_5550);
    chk("ret_after_pop_redir", bus.out_redirect, 0);

    // Slot1 beq -8 with no BTB hit: static backward-taken.
    send(32'h0000_3000, NOP, BEQM8, 2'b11, 34'd0, 34'd0, 32'h0000_3008);
    chk("beq_back_npc", bus.out_npc, 32'h0000_2FFC);
    chk("beq_back_redir", bus.out_redirect, 1);
    chk("beq_back_sv", bus.out_slot_valid, 2'b11);
    chk("beq_back_tp", bus.out_type_pcpre, {2'b01, 32'h0000_2FFC, 2'b00, 32'h0000_3004});

    // Forward beq: not taken without BTB, taken when the BTB agrees with the decoded target.
    send(32'h0000_4000, BEQP16, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_4008);
    chk("beq_fwd_nt_npc", bus.out_npc, 32'h0000_4008);
    chk("beq_fwd_nt_sv", bus.out_slot_valid, 2'b11);
    send(32'h0000_4000, BEQP16, NOP, 2'b11, {2'b01, 32'h0000_4010}, 34'd0, 32'h0000_4010);
    chk("beq_fwd_btb_npc", bus.out_npc, 32'h0000_4010);
    chk("beq_fwd_btb_redir", bus.out_redirect, 0);
    chk("beq_fwd_btb_sv", bus.out_slot_valid, 2'b01);
    send(32'h0000_4000, BEQP16, NOP, 2'b11, {2'b01, 32'h0000_9990}, 34'd0, 32'h0000_9990);
    chk("beq_bad_btb_npc", bus.out_npc, 32'h0000_4008);
    chk("beq_bad_btb_redir", bus.out_redirect, 1);

    // Stall with out_ready low, flush in the second stalled cycle, then flush drops a presented bl.
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("idle_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(32'h0000_6000, NOP, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_6008);
    @(posedge clk);
    #1;
    chk("stall_a_valid", bus.out_valid, 1);
    @(negedge clk);
    drive(32'h0000_7000, BL100, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_7100);
    chk("stall_in_ready_c1", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("stall_pc_c1", bus.out_pc, 32'h0000_6000);
    chk("stall_npc_c1", bus.out_npc, 32'h0000_6008);
    chk("stall_valid_c1", bus.out_valid, 1);
    @(negedge clk);
    bus.flush = 1'b1;
    chk("stall_in_ready_c2", bus.in_ready, 0);
    chk("stall_pc_c2", bus.out_pc, 32'h0000_6000);
    @(posedge clk);
    #1;
    chk("flush_kills_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("flush_drop_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h0000_3000, RET, NOP, 2'b11, {2'b11, 32'h0000_5550}, 34'd0, 32'h0000_5550);
    chk("flush_no_push_npc", bus.out_npc, 32'h0000_5550);

    // Nine bl pushes overflow the 8-deep RAS; nine returns pop newest first, ninth uses the BTB.
    for (int k = 0; k < 9; k++) begin
      send(32'h0000_8000 + 32'(k * 32'h100), BL100, NOP, 2'b01, 34'd0, 34'd0,
           32'h0000_8100 + 32'(k * 32'h100));
    end
    chk("bl9_redirect", bus.out_redirect, 0);
    for (int j = 0; j < 9; j++) begin
      send(32'h0000_9000, RET, NOP, 2'b11, {2'b11, 32'h0000_A000}, 34'd0, 32'h0000_9008);
      if (j < 8) chk($sformatf("ras_pop%0d_npc", j), bus.out_npc, 32'h0000_8004 + 32'((8 - j) * 32'h100));
      else       chk("ras_empty_npc", bus.out_npc, 32'h0000_A000);
    end

    // Straight-line packets: full, partial and empty slot masks.
    send(32'h0000_B000, NOP, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_B008);
    chk("seq_redirect", bus.out_redirect, 0);
    chk("seq_sv", bus.out_slot_valid, 2'b11);
    chk("seq_npc", bus.out_npc, 32'h0000_B008);
    send(32'h0000_B000, NOP, NOP, 2'b01, 34'd0, 34'd0, 32'h0000_B008);
    chk("part_npc", bus.out_npc, 32'h0000_B004);
    chk("part_redirect", bus.out_redirect, 1);
    send(32'h0000_B000, B40, NOP, 2'b00, 34'd0, 34'd0, 32'h0000_C000);
    chk("none_npc", bus.out_npc, 32'h0000_C000);
    chk("none_redirect", bus.out_redirect, 0);
    chk("none_sv", bus.out_slot_valid, 2'b00);

    // Wrapping PC at the top of the address space.
    send(32'hFFFF_FFFC, NOP, NOP, 2'b11, 34'd0, 34'd0, 32'h0000_0004);
    chk("wrap_npc", bus.out_npc, 32'h0000_0004);
    chk("wrap_redirect", bus.out_redirect, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
